lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the 64-bit, 256-word data memory (sync write, combinational read gated by r).
- Accepts byte-addressed load/store requests from the pipeline MEM stage and drives the memory's word address, write data, w and r.
- Performs sub-word extraction with sign/zero extension on loads, and read-modify-write merging on sub-word stores.
- Returns one registered response per request over a valid/ready handshake.

Parameters:
- DEPTH, 256, number of 64-bit words in the attached memory; word index >= DEPTH is an access error.
- AW, 64, width of the byte address and of mem_adr.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word (32-bit), 11 dword.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  AW  byte address.
- req_wdata  in  64  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  64  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.
- mem_adr  out  AW  word index (byte address >> 3), zero-extended.
- mem_datain  out  64  write word to memory.
- mem_w  out  1  memory write enable.
- mem_r  out  1  memory read enable.
- mem_dataout  in  64  memory read word (combinational).

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; mem_adr=0; mem_datain=0; mem_w=0; mem_r=0.
- Request capture:
  - In IDLE, req_ready=1. Handshake on req_valid&&req_ready at edge T captures all request fields.
  - In every other state req_ready=0.
- Error check at capture:
  - Misaligned: addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for dword.
  - Out of range: (addr>>3) >= DEPTH.
  - Either condition goes to RESP with rsp_err=1, rsp_data=0 and no mem_r/mem_w pulse.
- FSM states: IDLE, ACCESS, WRITE, RESP.
  - IDLE -> ACCESS on an accepted legal request; IDLE -> RESP on an illegal one.
  - ACCESS, load: mem_r=1. Lane selected by addr[2:0], extended per req_size/req_unsigned, registered into rsp_data -> RESP. rsp_valid rises at T+2.
  - ACCESS, dword store: mem_w=1, mem_datain=req_wdata (write commits at end of ACCESS) -> RESP. rsp_valid at T+2.
  - ACCESS, sub-word store: mem_r=1. Old word captured with the new lane merged in (byte lanes little-endian, lane = addr[2:0]) -> WRITE.
  - WRITE: mem_w=1, mem_datain=merged word -> RESP. rsp_valid at T+3.
  - RESP: rsp_valid=1, held stable until rsp_ready; on rsp_valid&&rsp_ready -> IDLE. A new request is accepted no earlier than the following cycle.
- Memory-side signals:
  - mem_r and mem_w are decoded from state; never both 1.
  - mem_adr is registered at capture and held until the next capture.
- Reset mid-operation: all outputs go to reset values immediately.
  - A write is committed only if a WRITE or store-ACCESS edge already occurred.
  - Memory contents are not cleared.
- rsp_err=1 only in RESP for an illegal request; otherwise 0.

Optional Feature:
- Macro: LSU_PERF_EN.
- When defined: extra outputs perf_loads, perf_stores, perf_errs, each 32-bit.
  - Each counter increments once per completed response handshake of its kind; errors count only in perf_errs.
  - Counters wrap at 2^32 and reset to 0.
- When undefined: no ports, no counters, identical timing otherwise.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum IDLE/ACCESS/WRITE/RESP;
  - the DEPTH default constant.
- Sub-module lsu_align is purely combinational:
  - load: extract+extend (word, offset, size, unsigned) -> data;
  - store: merge (old word, wdata, offset, size) -> new word.

Test Plan:
- Bench memory preloaded with every word = 0x0000_0000_0000_0001.
- Dword store addr 0x10, data 0xDEAD_BEEF_CAFE_F00D -> one mem_w pulse, mem_adr=2; rsp_valid at T+2, rsp_err=0. Dword load addr 0x10 returns 0xDEAD_BEEF_CAFE_F00D.
- Byte store addr 0x13, data 0xAB to that word -> mem_r then mem_w, rsp at T+3; word becomes 0xDEAD_BEEF_ABFE_F00D. Signed byte load 0x13 -> 0xFFFF_FFFF_FFFF_FFAB; unsigned -> 0xAB.
- Half load addr 0x11 -> rsp_err=1, rsp_data=0, no mem_r/mem_w, rsp_valid at T+1. Dword load addr 0x800 (index 256) -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid/rsp_data stable, req_ready=0 throughout; accept resumes the cycle after the handshake.
- Assert rst_n=0 during WRITE of a byte store -> mem_w drops immediately, target word unchanged, all outputs at reset values.
- With LSU_PERF_EN: 3 loads, 2 stores, 1 misaligned -> perf_loads=3, perf_stores=2, perf_errs=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// default memory depth and small access-rule helpers.
package lsu_pkg;

  localparam int LSU_DEPTH = 256;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } lsu_state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off[1:0] != 2'b00);
      default: bad = (off != 3'b000);
    endcase
    return bad;
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge
// on a little-endian 64-bit word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [5:0]  shamt_s;
  logic [63:0] shifted_s;
  logic [63:0] lane_mask_s;
  logic        sign_s;

  // Right-align the addressed lane and sign/zero extend it to 64 bits.
  always_comb begin
    shamt_s     = {offset, 3'b000};
    shifted_s   = word >> shamt_s;
    sign_s      = 1'b0;
    load_data   = 64'd0;
    case (size)
      SZ_B: begin
        sign_s    = ~is_unsigned & shifted_s[7];
        load_data = {{56{sign_s}}, shifted_s[7:0]};
      end
      SZ_H: begin
        sign_s    = ~is_unsigned & shifted_s[15];
        load_data = {{48{sign_s}}, shifted_s[15:0]};
      end
      SZ_W: begin
        sign_s    = ~is_unsigned & shifted_s[31];
        load_data = {{32{sign_s}}, shifted_s[31:0]};
      end
      default: begin
        load_data = shifted_s;
      end
    endcase
  end

  // Replace only the addressed lane of the old word with the new store data.
  always_comb begin
    lane_mask_s = size_mask(size) << shamt_s;
    merged      = (word & ~lane_mask_s) | ((wdata & size_mask(size)) << shamt_s);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a 64-bit x DEPTH data memory.
// Optional feature macro LSU_PERF_EN adds 32-bit load/store/error counters.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH = LSU_DEPTH,
  parameter int AW    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [63:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] mem_adr,
  output logic [63:0]   mem_datain,
  output logic          mem_w,
  output logic          mem_r,
  input  logic [63:0]   mem_dataout
`ifdef LSU_PERF_EN
  ,
  output logic [31:0]   perf_loads,
  output logic [31:0]   perf_stores,
  output logic [31:0]   perf_errs
`endif
);

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  lsu_state_t  state_r;
  logic        store_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [2:0]  off_r;
  logic [63:0] wdata_r;

  logic [AW-1:0] word_idx_s;
  logic          illegal_s;
  logic          accept_s;
  logic [63:0]   load_data_s;
  logic [63:0]   merged_s;

  // Classify the incoming request before it is captured.
  always_comb begin
    word_idx_s = {3'b000, req_addr[AW-1:3]};
    illegal_s  = misaligned(req_size, req_addr[2:0]) || (word_idx_s >= DEPTH_W);
    accept_s   = req_valid && req_ready;
  end

  lsu_align u_align (
    .word        (mem_dataout),
    .offset      (off_r),
    .size        (size_r),
    .is_unsigned (uns_r),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .merged      (merged_s)
  );

  // Main FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 64'd0;
      rsp_err    <= 1'b0;
      mem_adr    <= '0;
      mem_datain <= 64'd0;
      mem_w      <= 1'b0;
      mem_r      <= 1'b0;
      store_r    <= 1'b0;
      size_r     <= SZ_B;
      uns_r      <= 1'b0;
      off_r      <= 3'd0;
      wdata_r    <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            store_r   <= req_store;
            size_r    <= req_size;
            uns_r     <= req_unsigned;
            off_r     <= req_addr[2:0];
            wdata_r   <= req_wdata;
            mem_adr   <= word_idx_s;
            req_ready <= 1'b0;
            if (illegal_s) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 64'd0;
            end else if (req_store && (req_size == SZ_D)) begin
              state_r    <= ACCESS;
              mem_w      <= 1'b1;
              mem_datain <= req_wdata;
            end else begin
              state_r <= ACCESS;
              mem_r   <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (!store_r) begin
            mem_r     <= 1'b0;
            rsp_data  <= load_data_s;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else if (size_r == SZ_D) begin
            mem_w     <= 1'b0;
            rsp_data  <= 64'd0;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            // Old word is valid this cycle; write the merged word next cycle.
            mem_r      <= 1'b0;
            mem_w      <= 1'b1;
            mem_datain <= merged_s;
            state_r    <= WRITE;
          end
        end
        WRITE: begin
          mem_w     <= 1'b0;
          rsp_data  <= 64'd0;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 64'd0;
            req_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          mem_w     <= 1'b0;
          mem_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef LSU_PERF_EN
  // Count completed response handshakes by kind; errors are counted only as errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= 32'd0;
      perf_stores <= 32'd0;
      perf_errs   <= 32'd0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_err) begin
        perf_errs <= perf_errs + 32'd1;
      end else if (store_r) begin
        perf_stores <= perf_stores + 32'd1;
      end else begin
        perf_loads <= perf_loads + 32'd1;
      end
    end else begin
      perf_errs <= perf_errs;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed plan steps plus randomized
// traffic against a byte-level reference memory model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [63:0] mem_adr;
  logic [63:0] mem_datain;
  logic        mem_w;
  logic        mem_r;
  logic [63:0] mem_dataout;
`ifdef LSU_PERF_EN
  logic [31:0] perf_loads;
  logic [31:0] perf_stores;
  logic [31:0] perf_errs;
`endif

  int vectors = 0;
  int miscompares = 0;
  int m_loads = 0;
  int m_stores = 0;
  int m_errs = 0;

  logic [63:0] bmem [256];
  logic [63:0] ref_mem [256];

  lsu_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .mem_adr      (mem_adr),
    .mem_datain   (mem_datain),
    .mem_w        (mem_w),
    .mem_r        (mem_r),
    .mem_dataout  (mem_dataout)
`ifdef LSU_PERF_EN
    ,
    .perf_loads   (perf_loads),
    .perf_stores  (perf_stores),
    .perf_errs    (perf_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached data memory: synchronous write, combinational read gated by r.
  always @(posedge clk) begin
    if (mem_w && (mem_adr < 64'd256)) bmem[mem_adr[7:0]] <= mem_datain;
  end
  assign mem_dataout = (mem_r && (mem_adr < 64'd256)) ? bmem[mem_adr[7:0]] : 64'd0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-wise access rules from the unit's contract.
  task automatic ref_access(input logic st, input logic [1:0] sz, input logic un,
                            input logic [63:0] addr, input logic [63:0] wd,
                            output logic [63:0] e_data, output logic e_err,
                            output int e_lat, output int e_nr, output int e_nw);
    int nb;
    int off;
    logic [63:0] idx;
    logic [63:0] w;
    nb  = 1 << sz;
    off = int'(addr % 64'd8);
    idx = addr / 64'd8;
    e_err  = ((addr % 64'(nb)) != 64'd0) || (idx >= 64'd256);
    e_data = 64'd0;
    if (e_err) begin
      e_lat = 1; e_nr = 0; e_nw = 0;
      m_errs++;
    end else if (!st) begin
      w = ref_mem[idx[7:0]];
      for (int i = 0; i < nb; i++) e_data[8*i +: 8] = w[8*(off+i) +: 8];
      if (!un && nb < 8 && e_data[8*nb-1])
        for (int i = nb; i < 8; i++) e_data[8*i +: 8] = 8'hFF;
      e_lat = 2; e_nr = 1; e_nw = 0;
      m_loads++;
    end else begin
      w = ref_mem[idx[7:0]];
      for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
      ref_mem[idx[7:0]] = w;
      e_lat = (nb == 8) ? 2 : 3;
      e_nr  = (nb == 8) ? 0 : 1;
      e_nw  = 1;
      m_stores++;
    end
  endtask

  task automatic run_req(input logic st, input logic [1:0] sz, input logic un,
                         input logic [63:0] addr, input logic [63:0] wd, input int hold,
                         output logic [63:0] got);
    logic [63:0] e_data;
    logic        e_err;
    int e_lat, e_nr, e_nw;
    int k, nr, nw, both;
    ref_access(st, sz, un, addr, wd, e_data, e_err, e_lat, e_nr, e_nw);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = addr; req_wdata = wd; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0; nr = 0; nw = 0; both = 0;
    while (!rsp_valid && k < 8) begin
      nr += int'(mem_r); nw += int'(mem_w);
      if (mem_r && mem_w) both++;
      @(posedge clk); #1;
      k++;
    end
    nr += int'(mem_r); nw += int'(mem_w);
    chk("rsp_latency", 64'(k + 1), 64'(e_lat));
    chk("mem_r_cycles", 64'(nr), 64'(e_nr));
    chk("mem_w_cycles", 64'(nw), 64'(e_nw));
    chk("mem_r_w_both", 64'(both), 64'd0);
    chk("mem_adr", mem_adr, addr >> 3);
    chk("rsp_err", 64'(rsp_err), 64'(e_err));
    chk("rsp_data", rsp_data, e_data);
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    got = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", rsp_data, e_data);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_valid", 64'(rsp_valid), 64'd0);
    chk("post_hs_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_mem_adr"}, mem_adr, 64'd0);
    chk({tag, "_mem_datain"}, mem_datain, 64'd0);
    chk({tag, "_mem_w"}, 64'(mem_w), 64'd0);
    chk({tag, "_mem_r"}, 64'(mem_r), 64'd0);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] a;
    logic [1:0]  sz;
    int hold;
    for (int i = 0; i < 256; i++) begin
      bmem[i] = 64'd1;
      ref_mem[i] = 64'd1;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = SZ_B;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Dword store, then read it back.
    run_req(1'b1, SZ_D, 1'b0, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 0, got);
    chk("dword_mem", bmem[2], 64'hDEAD_BEEF_CAFE_F00D);
    run_req(1'b0, SZ_D, 1'b0, 64'h10, 64'd0, 0, got);
    chk("dword_load", got, 64'hDEAD_BEEF_CAFE_F00D);

    // Byte store merge and signed/unsigned byte loads.
    run_req(1'b1, SZ_B, 1'b0, 64'h13, 64'h0000_0000_0000_00AB, 0, got);
    chk("byte_merge_mem", bmem[2], 64'hDEAD_BEEF_ABFE_F00D);
    run_req(1'b0, SZ_B, 1'b0, 64'h13, 64'd0, 0, got);
    chk("byte_load_s", got, 64'hFFFF_FFFF_FFFF_FFAB);
    run_req(1'b0, SZ_B, 1'b1, 64'h13, 64'd0, 0, got);
    chk("byte_load_u", got, 64'h0000_0000_0000_00AB);

    // Misaligned and out-of-range accesses.
    run_req(1'b0, SZ_H, 1'b0, 64'h11, 64'd0, 0, got);
    run_req(1'b0, SZ_D, 1'b0, 64'h800, 64'd0, 0, got);
    run_req(1'b1, SZ_W, 1'b0, 64'h7F8, 64'h1234_5678, 0, got);

    // Backpressure on a load response.
    run_req(1'b0, SZ_W, 1'b0, 64'h14, 64'd0, 5, got);
    chk("bp_load", got, 64'hFFFF_FFFF_DEAD_BEEF);

    // Reset while a byte store is in its write cycle.
    req_valid = 1'b1; req_store = 1'b1; req_size = SZ_B; req_unsigned = 1'b0;
    req_addr = 64'h1A; req_wdata = 64'h2B; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("write_phase_mem_w", 64'(mem_w), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    m_loads = 0; m_stores = 0; m_errs = 0;
    @(posedge clk); #1;
    chk("midrst_word_kept", bmem[3], 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 64'($urandom_range(0, 2303));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      if ($urandom_range(0, 19) == 0) a = {32'($urandom), 32'($urandom)} & ~64'd7;
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              {32'($urandom), 32'($urandom)}, hold, got);
    end
    for (int i = 0; i < 256; i++) chk("final_mem", bmem[i], ref_mem[i]);

`ifdef LSU_PERF_EN
    chk("perf_loads", 64'(perf_loads), 64'(m_loads));
    chk("perf_stores", 64'(perf_stores), 64'(m_stores));
    chk("perf_errs", 64'(perf_errs), 64'(m_errs));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
